// File: rtl/cfg_write_arbiter.sv
// Round-robin two-requester write arbiter owning the PWM/output config bank.
// Define CFG_WRITE_ARB_SHADOW_EN for shadowed writes committed by a write to addr 5.
module cfg_write_arbiter #(
  parameter int unsigned PRIO_INIT = 0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req0_valid,
  input  logic [6:0] req0_addr,
  input  logic [7:0] req0_data,
  output logic       req0_ready,
  input  logic       req1_valid,
  input  logic [6:0] req1_addr,
  input  logic [7:0] req1_data,
  output logic       req1_ready,
  output logic [7:0] en_reg_out_7_0,
  output logic [7:0] en_reg_out_15_8,
  output logic [7:0] en_reg_pwm_7_0,
  output logic [7:0] en_reg_pwm_15_8,
  output logic [7:0] pwm_duty_cycle,
  output logic       wr_err
);

  typedef enum logic {
    IDLE  = 1'b0,
    WRITE = 1'b1
  } state_t;

  // Pointer starts on the loser so PRIO_INIT wins the first collision.
  localparam logic LAST_GNT_RST = (PRIO_INIT == 0) ? 1'b1 : 1'b0;

  state_t     r_state;
  state_t     w_state_nxt;
  logic       r_last_gnt;
  logic [6:0] r_addr;
  logic [7:0] r_data;
  logic       r_wr_err;
  logic [7:0] r_out_lo;
  logic [7:0] r_out_hi;
  logic [7:0] r_pwm_lo;
  logic [7:0] r_pwm_hi;
  logic [7:0] r_duty;
  logic       w_any;
  logic       w_gnt;
  logic       w_accept;

`ifdef CFG_WRITE_ARB_SHADOW_EN
  logic [7:0] r_sh_out_lo;
  logic [7:0] r_sh_out_hi;
  logic [7:0] r_sh_pwm_lo;
  logic [7:0] r_sh_pwm_hi;
  logic [7:0] r_sh_duty;
`endif

  always_comb begin
    w_any = req0_valid | req1_valid;
    w_gnt = 1'b0;
    if (req0_valid && req1_valid) begin
      w_gnt = ~r_last_gnt;
    end else if (req1_valid) begin
      w_gnt = 1'b1;
    end
    w_accept = (r_state == IDLE) && w_any;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_any) w_state_nxt = WRITE;
      WRITE:   w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // State resets to IDLE asynchronously, so readys are also gated by rst_n.
  always_comb begin
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    if (rst_n && (r_state == IDLE) && w_any) begin
      req0_ready = ~w_gnt;
      req1_ready = w_gnt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_addr     <= '0;
      r_data     <= '0;
      r_last_gnt <= LAST_GNT_RST;
      r_wr_err   <= 1'b0;
      r_out_lo   <= '0;
      r_out_hi   <= '0;
      r_pwm_lo   <= '0;
      r_pwm_hi   <= '0;
      r_duty     <= '0;
`ifdef CFG_WRITE_ARB_SHADOW_EN
      r_sh_out_lo <= '0;
      r_sh_out_hi <= '0;
      r_sh_pwm_lo <= '0;
      r_sh_pwm_hi <= '0;
      r_sh_duty   <= '0;
`endif
    end else begin
      r_wr_err <= 1'b0;
      if (w_accept) begin
        r_addr     <= w_gnt ? req1_addr : req0_addr;
        r_data     <= w_gnt ? req1_data : req0_data;
        r_last_gnt <= w_gnt;
      end
      if (r_state == WRITE) begin
        case (r_addr)
`ifdef CFG_WRITE_ARB_SHADOW_EN
          7'd0: r_sh_out_lo <= r_data;
          7'd1: r_sh_out_hi <= r_data;
          7'd2: r_sh_pwm_lo <= r_data;
          7'd3: r_sh_pwm_hi <= r_data;
          7'd4: r_sh_duty   <= r_data;
          7'd5: begin
            r_out_lo <= r_sh_out_lo;
            r_out_hi <= r_sh_out_hi;
            r_pwm_lo <= r_sh_pwm_lo;
            r_pwm_hi <= r_sh_pwm_hi;
            r_duty   <= r_sh_duty;
          end
`else
          7'd0: r_out_lo <= r_data;
          7'd1: r_out_hi <= r_data;
          7'd2: r_pwm_lo <= r_data;
          7'd3: r_pwm_hi <= r_data;
          7'd4: r_duty   <= r_data;
`endif
          default: r_wr_err <= 1'b1;
        endcase
      end
    end
  end

  assign en_reg_out_7_0  = r_out_lo;
  assign en_reg_out_15_8 = r_out_hi;
  assign en_reg_pwm_7_0  = r_pwm_lo;
  assign en_reg_pwm_15_8 = r_pwm_hi;
  assign pwm_duty_cycle  = r_duty;
  assign wr_err          = r_wr_err;

endmodule

// File: tb/tb_cfg_write_arbiter.sv
// Scoreboard bench for cfg_write_arbiter; expected writes queued at drive time.
module tb_cfg_write_arbiter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       v0, v1;
  logic [6:0] a0, a1;
  logic [7:0] d0, d1;
  logic       req0_ready, req1_ready;
  logic [7:0] o_lo, o_hi, p_lo, p_hi, duty;
  logic       wr_err;

  typedef struct packed {
    logic       req;
    logic [6:0] addr;
    logic [7:0] data;
  } item_t;

  item_t      sb[$];
  logic [7:0] m_reg[5];
  logic [7:0] m_sh[5];
  int         tests = 0;
  int         fails = 0;
  logic [39:0] w_vec;

  always #5 clk = ~clk;

  cfg_write_arbiter #(.PRIO_INIT(0)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(v0), .req0_addr(a0), .req0_data(d0), .req0_ready(req0_ready),
    .req1_valid(v1), .req1_addr(a1), .req1_data(d1), .req1_ready(req1_ready),
    .en_reg_out_7_0(o_lo), .en_reg_out_15_8(o_hi),
    .en_reg_pwm_7_0(p_lo), .en_reg_pwm_15_8(p_hi),
    .pwm_duty_cycle(duty), .wr_err(wr_err)
  );

  assign w_vec = {o_lo, o_hi, p_lo, p_hi, duty};

  function automatic logic [39:0] exp_vec();
    return {m_reg[0], m_reg[1], m_reg[2], m_reg[3], m_reg[4]};
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < 5; i++) begin
      m_reg[i] = 8'h00;
      m_sh[i]  = 8'h00;
    end
  endfunction

  // Applies one accepted write to the register model; returns expected wr_err.
  function automatic logic model_write(item_t t);
`ifdef CFG_WRITE_ARB_SHADOW_EN
    if (t.addr < 7'd5) begin
      m_sh[t.addr[2:0]] = t.data;
      return 1'b0;
    end
    if (t.addr == 7'd5) begin
      for (int i = 0; i < 5; i++) m_reg[i] = m_sh[i];
      return 1'b0;
    end
    return 1'b1;
`else
    if (t.addr < 7'd5) begin
      m_reg[t.addr[2:0]] = t.data;
      return 1'b0;
    end
    return 1'b1;
`endif
  endfunction

  task automatic test_reset();
    rst_n = 1'b0;
    v0 = 1'b1; v1 = 1'b1;
    a0 = 7'd0; a1 = 7'd1; d0 = 8'h11; d1 = 8'h22;
    model_reset();
    @(negedge clk);
    tests++;
    if ({req1_ready, req0_ready} !== 2'b00) begin
      fails++; $display("FAIL reset_ready: got %b expected 00", {req1_ready, req0_ready});
    end
    tests++;
    if (w_vec !== 40'h0 || wr_err !== 1'b0) begin
      fails++; $display("FAIL reset_outputs: got %h/%b expected 0/0", w_vec, wr_err);
    end
    v0 = 1'b0; v1 = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    item_t q0[2];
    item_t q1[2];
    item_t t;
    int p0 = 0, p1 = 0, due = -1, last = -1;
    logic e_err = 1'b0;
    q0[0] = {1'b0, 7'd0, 8'hAA}; q0[1] = {1'b0, 7'd2, 8'hC3};
    q1[0] = {1'b1, 7'd1, 8'h55}; q1[1] = {1'b1, 7'd4, 8'h3C};
    sb.push_back(q0[0]); sb.push_back(q1[0]); sb.push_back(q0[1]); sb.push_back(q1[1]);
    v0 = 1'b1; a0 = q0[0].addr; d0 = q0[0].data;
    v1 = 1'b1; a1 = q1[0].addr; d1 = q1[0].data;
    for (int c = 0; c < 24 && (sb.size() != 0 || due >= 0); c++) begin
      @(negedge clk);
      if (c == due) begin
        tests++;
        if (w_vec !== exp_vec() || wr_err !== e_err) begin
          fails++; $display("FAIL b2b_outputs: got %h/%b expected %h/%b", w_vec, wr_err, exp_vec(), e_err);
        end
        due = -1;
      end
      if (req0_ready || req1_ready) begin
        tests++;
        if (sb.size() == 0) begin
          fails++; $display("FAIL b2b_extra_grant: got %b expected 00", {req1_ready, req0_ready});
          break;
        end
        t = sb.pop_front();
        if ({req1_ready, req0_ready} !== (t.req ? 2'b10 : 2'b01)) begin
          fails++; $display("FAIL b2b_grant: got %b expected %b", {req1_ready, req0_ready}, t.req ? 2'b10 : 2'b01);
        end
        if (last >= 0) begin
          tests++;
          if (c - last != 2) begin
            fails++; $display("FAIL b2b_spacing: got %0d expected 2", c - last);
          end
        end
        last = c;
        e_err = model_write(t);
        due = c + 2;
        @(posedge clk); #1;
        if (!t.req) begin
          p0++;
          if (p0 < 2) begin a0 = q0[p0].addr; d0 = q0[p0].data; end else v0 = 1'b0;
        end else begin
          p1++;
          if (p1 < 2) begin a1 = q1[p1].addr; d1 = q1[p1].data; end else v1 = 1'b0;
        end
      end
    end
    tests++;
    if (sb.size() != 0 || due >= 0) begin
      fails++; $display("FAIL b2b_timeout: got %0d pending expected 0", sb.size());
    end
    v0 = 1'b0; v1 = 1'b0;
    sb.delete();
    @(posedge clk); #1;
  endtask

  task automatic test_single_write();
    item_t t;
    logic e;
    logic [39:0] old;
    a0 = 7'd4; d0 = 8'h80; v0 = 1'b1;
    sb.push_back({1'b0, 7'd4, 8'h80});
    @(negedge clk);
    tests++;
    if ({req1_ready, req0_ready} !== 2'b01) begin
      fails++; $display("FAIL single_ready: got %b expected 01", {req1_ready, req0_ready});
    end
    old = exp_vec();
    t = sb.pop_front();
    e = model_write(t);
    @(posedge clk); #1; v0 = 1'b0;
    @(negedge clk);
    tests++;
    if ({req1_ready, req0_ready} !== 2'b00 || w_vec !== old) begin
      fails++; $display("FAIL single_write_cycle: got %b/%h expected 00/%h", {req1_ready, req0_ready}, w_vec, old);
    end
    @(negedge clk);
    tests++;
    if (w_vec !== exp_vec() || wr_err !== e) begin
      fails++; $display("FAIL single_result: got %h/%b expected %h/%b", w_vec, wr_err, exp_vec(), e);
    end
`ifndef CFG_WRITE_ARB_SHADOW_EN
    tests++;
    if (duty !== 8'h80) begin
      fails++; $display("FAIL single_duty: got %h expected 80", duty);
    end
`endif
    @(posedge clk); #1;
  endtask

  task automatic test_unmapped();
    item_t t;
    logic e;
    logic [39:0] old;
    a1 = 7'h12; d1 = 8'hFF; v1 = 1'b1;
    sb.push_back({1'b1, 7'h12, 8'hFF});
    @(negedge clk);
    tests++;
    if ({req1_ready, req0_ready} !== 2'b10) begin
      fails++; $display("FAIL unmapped_ready: got %b expected 10", {req1_ready, req0_ready});
    end
    old = exp_vec();
    t = sb.pop_front();
    e = model_write(t);
    @(posedge clk); #1; v1 = 1'b0;
    @(negedge clk);
    tests++;
    if (wr_err !== 1'b0) begin
      fails++; $display("FAIL unmapped_err_early: got %b expected 0", wr_err);
    end
    @(negedge clk);
    tests++;
    if (wr_err !== e || w_vec !== old) begin
      fails++; $display("FAIL unmapped_err: got %b/%h expected %b/%h", wr_err, w_vec, e, old);
    end
    @(negedge clk);
    tests++;
    if (wr_err !== 1'b0) begin
      fails++; $display("FAIL unmapped_err_width: got %b expected 0", wr_err);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_addr5();
    item_t tab[$];
    item_t t;
    logic e;
    logic [39:0] old;
`ifdef CFG_WRITE_ARB_SHADOW_EN
    tab.push_back({1'b0, 7'd0, 8'h01});
    tab.push_back({1'b1, 7'd3, 8'h02});
    tab.push_back({1'b0, 7'd5, 8'h99});
`else
    tab.push_back({1'b0, 7'd5, 8'h77});
`endif
    foreach (tab[k]) begin
      if (tab[k].req) begin a1 = tab[k].addr; d1 = tab[k].data; v1 = 1'b1; end
      else begin a0 = tab[k].addr; d0 = tab[k].data; v0 = 1'b1; end
      sb.push_back(tab[k]);
      @(negedge clk);
      t = sb.pop_front();
      tests++;
      if ({req1_ready, req0_ready} !== (t.req ? 2'b10 : 2'b01)) begin
        fails++; $display("FAIL addr5_ready: got %b expected %b", {req1_ready, req0_ready}, t.req ? 2'b10 : 2'b01);
      end
      old = exp_vec();
      e = model_write(t);
      @(posedge clk); #1; v0 = 1'b0; v1 = 1'b0;
      @(negedge clk);
      tests++;
      if (w_vec !== old) begin
        fails++; $display("FAIL addr5_early: got %h expected %h", w_vec, old);
      end
      @(negedge clk);
      tests++;
      if (w_vec !== exp_vec() || wr_err !== e) begin
        fails++; $display("FAIL addr5_result: got %h/%b expected %h/%b", w_vec, wr_err, exp_vec(), e);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset_mid_write();
    item_t t;
    logic e;
    logic [39:0] old;
    a0 = 7'd2; d0 = 8'h0F; v0 = 1'b1;
    sb.push_back({1'b0, 7'd2, 8'h0F});
    @(negedge clk);
    t = sb.pop_front();
    tests++;
    if ({req1_ready, req0_ready} !== 2'b01) begin
      fails++; $display("FAIL rstmid_accept: got %b expected 01", {req1_ready, req0_ready});
    end
    @(posedge clk); #1;
    rst_n = 1'b0;
    model_reset();
    v0 = 1'b1; a0 = 7'd3; d0 = 8'h11;
    v1 = 1'b1; a1 = 7'd4; d1 = 8'h22;
    @(negedge clk);
    tests++;
    if ({req1_ready, req0_ready} !== 2'b00) begin
      fails++; $display("FAIL rstmid_ready: got %b expected 00", {req1_ready, req0_ready});
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    tests++;
    if (p_lo !== 8'h00 || w_vec !== exp_vec()) begin
      fails++; $display("FAIL rstmid_discard: got %h expected %h", w_vec, exp_vec());
    end
    sb.push_back({1'b0, 7'd3, 8'h11});
    sb.push_back({1'b1, 7'd4, 8'h22});
    t = sb.pop_front();
    tests++;
    if ({req1_ready, req0_ready} !== (t.req ? 2'b10 : 2'b01)) begin
      fails++; $display("FAIL rstmid_prio: got %b expected %b", {req1_ready, req0_ready}, t.req ? 2'b10 : 2'b01);
    end
    old = exp_vec();
    e = model_write(t);
    @(posedge clk); #1; v0 = 1'b0;
    @(negedge clk);
    tests++;
    if (w_vec !== old) begin
      fails++; $display("FAIL rstmid_early: got %h expected %h", w_vec, old);
    end
    @(negedge clk);
    t = sb.pop_front();
    tests++;
    if (w_vec !== exp_vec() || wr_err !== e || {req1_ready, req0_ready} !== (t.req ? 2'b10 : 2'b01)) begin
      fails++; $display("FAIL rstmid_second: got %h/%b/%b expected %h/%b/%b", w_vec, wr_err,
                        {req1_ready, req0_ready}, exp_vec(), e, t.req ? 2'b10 : 2'b01);
    end
    e = model_write(t);
    @(posedge clk); #1; v1 = 1'b0;
    @(negedge clk);
    @(negedge clk);
    tests++;
    if (w_vec !== exp_vec() || wr_err !== e) begin
      fails++; $display("FAIL rstmid_final: got %h/%b expected %h/%b", w_vec, wr_err, exp_vec(), e);
    end
    @(posedge clk); #1;
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_single_write();
    test_unmapped();
    test_addr5();
    test_reset_mid_write();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
